// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared CORDIC constants and types: fixed-point widths, arctan
//            table, gain-compensation factor, pi/2 and the controller states.
//            Used by both the rotation-mode and vectoring-mode blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Fixed-point widths (all with 16 fractional bits)
  localparam int C_FRAC_W = 16;
  localparam int C_DATA_W = 18;  // Q2.16 inputs / magnitude / atan entries
  localparam int C_INT_W  = 22;  // Q6.16 datapath with growth headroom
  localparam int C_ANG_W  = 19;  // Q3.16 angle, covers +/-pi

  // Arctan table: atan(2^-i) in Q2.16, truncated
  localparam int C_ATAN_N = 16;
  localparam int C_IDX_W  = 5;   // allows up to 32 iterations of indexing

  localparam logic [C_DATA_W-1:0] C_ATAN_TABLE [0:C_ATAN_N-1] = '{
    18'h0C90F, 18'h076B1, 18'h03EB6, 18'h01FD5,
    18'h00FFA, 18'h007FF, 18'h003FF, 18'h001FF,
    18'h000FF, 18'h0007F, 18'h0003F, 18'h0001F,
    18'h0000F, 18'h00007, 18'h00003, 18'h00001
  };

  // 1/K for the CORDIC gain, Q0.16 (~0.60725)
  localparam logic [15:0] C_GAIN = 16'h9B74;

  // pi/2 in Q3.16
  localparam logic signed [C_ANG_W-1:0] C_PI_2 = 19'sd102944;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREROT = 3'd1,
    ST_ITER   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan_rom
// Brief    : Combinational arctan lookup, atan(2^-idx) in Q2.16. Indices past
//            the end of the table return zero so deeper iteration counts are
//            harmless.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [C_IDX_W-1:0]  idx,
  output logic [C_DATA_W-1:0] atan
);

  // Table lookup with zero beyond the stored entries
  always_comb begin
    atan = '0;
    if (idx < C_IDX_W'(C_ATAN_N)) begin
      atan = C_ATAN_TABLE[idx[3:0]];
    end
  end

endmodule : cordic_atan_rom
`default_nettype wire

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vectoring
// Brief    : Iterative vectoring-mode CORDIC. Rotates (x, y) onto the positive
//            x axis, accumulating the angle atan2(y, x), then scales the
//            resulting x by 1/K to give the vector magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITERS  = 16,
  parameter int DATA_W = 18,
  parameter int INT_W  = 22,
  parameter int ANG_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] magnitude,
  output logic [ANG_W-1:0]  angle,
  output logic              busy,
  output logic              done
);

  // Product of x (INT_W signed) and the 16-bit gain held as a 17-bit signed
  localparam int PROD_W = INT_W + 17;
  localparam int SC_W   = PROD_W - C_FRAC_W;

  localparam logic [C_IDX_W-1:0]       C_LAST    = C_IDX_W'(ITERS - 1);
  localparam logic signed [ANG_W-1:0]  C_PI_2_Z  = ANG_W'(C_PI_2);

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_x_lat;
  logic signed [DATA_W-1:0]  r_y_lat;
  logic signed [INT_W-1:0]   r_x;
  logic signed [INT_W-1:0]   r_y;
  logic signed [ANG_W-1:0]   r_z;
  logic [C_IDX_W-1:0]        r_i;
  logic                      r_zero;

  logic [C_DATA_W-1:0]       w_atan;
  logic signed [ANG_W-1:0]   w_atan_ext;
  logic signed [INT_W-1:0]   w_x_ext;
  logic signed [INT_W-1:0]   w_y_ext;
  logic signed [INT_W-1:0]   w_x_sh;
  logic signed [INT_W-1:0]   w_y_sh;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SC_W-1:0]    w_scaled;
  logic [DATA_W-1:0]         w_mag;

  // Arctan of the current micro-rotation, shared ROM
  cordic_atan_rom u_atan_rom (
    .idx  (r_i),
    .atan (w_atan)
  );

  // Widen operands: inputs sign-extend, table entries are non-negative
  always_comb begin
    w_x_ext    = INT_W'(r_x_lat);
    w_y_ext    = INT_W'(r_y_lat);
    w_atan_ext = ANG_W'({1'b0, w_atan});
    w_x_sh     = r_x >>> r_i;
    w_y_sh     = r_y >>> r_i;
  end

  // Gain compensation: truncate the product, then clamp into [0, 2^DATA_W-1]
  always_comb begin
    w_prod   = PROD_W'(r_x) * PROD_W'($signed({1'b0, C_GAIN}));
    w_scaled = w_prod[PROD_W-1:C_FRAC_W];
    w_mag    = w_scaled[DATA_W-1:0];
    if (w_scaled[SC_W-1]) begin
      w_mag = '0;
    end else if (|w_scaled[SC_W-2:DATA_W]) begin
      w_mag = '1;
    end
  end

  // Controller and datapath: accept, prerotate, iterate, scale, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_x_lat   <= '0;
      r_y_lat   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_zero    <= 1'b0;
      magnitude <= '0;
      angle     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_x_lat <= x_in;
            r_y_lat <= y_in;
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= ST_PREROT;
          end
        end

        ST_PREROT: begin
          // Fold left-half-plane vectors into the right half by +/-90 deg;
          // y == 0 with x < 0 takes the +90 path so the result is +pi.
          if (r_x_lat[DATA_W-1] && !r_y_lat[DATA_W-1]) begin
            r_x <= w_y_ext;
            r_y <= -w_x_ext;
            r_z <= C_PI_2_Z;
          end else if (r_x_lat[DATA_W-1]) begin
            r_x <= -w_y_ext;
            r_y <= w_x_ext;
            r_z <= -C_PI_2_Z;
          end else begin
            r_x <= w_x_ext;
            r_y <= w_y_ext;
            r_z <= '0;
          end
          r_zero  <= (r_x_lat == '0) && (r_y_lat == '0);
          r_i     <= '0;
          r_state <= ST_ITER;
        end

        ST_ITER: begin
          if (!r_y[INT_W-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan_ext;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan_ext;
          end
          r_i <= r_i + C_IDX_W'(1);
          if (r_i == C_LAST) begin
            r_state <= ST_SCALE;
          end
        end

        ST_SCALE: begin
          // A zero vector has no defined angle; report exact zeros
          magnitude <= r_zero ? '0 : w_mag;
          angle     <= r_zero ? '0 : r_z;
          busy      <= 1'b0;
          done      <= 1'b1;
          r_state   <= ST_DONE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : cordic_vectoring
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vectoring
// Brief    : Self-checking bench for cordic_vectoring: directed vectors with
//            ideal-value tolerance checks, protocol checks, and randomized
//            vectors against an algorithmic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_vectoring;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [17:0] x_in;
  logic [17:0] y_in;
  logic [17:0] magnitude;
  logic [18:0] angle;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_fail = 0;

  longint atan_tab [16] = '{51471, 30385, 16054, 8149, 4090, 2047, 1023, 511,
                            255, 127, 63, 31, 15, 7, 3, 1};

  cordic_vectoring dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .magnitude (magnitude),
    .angle     (angle),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: quadrant fold, 16 shift-add micro-rotations, 1/K scaling
  function automatic void model(input longint xi, input longint yi,
                                output longint mag, output longint ang);
    longint x, y, z, xn, yn;
    if (xi < 0 && yi >= 0) begin
      x = yi; y = -xi; z = 102944;
    end else if (xi < 0) begin
      x = -yi; y = xi; z = -102944;
    end else begin
      x = xi; y = yi; z = 0;
    end
    for (int i = 0; i < 16; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
      end else begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
      end
      x = xn; y = yn;
    end
    mag = (x * 39796) >>> 16;
    if (mag < 0) mag = 0;
    if (mag > 262143) mag = 262143;
    ang = z;
    if (xi == 0 && yi == 0) begin
      mag = 0; ang = 0;
    end
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp,
                         input longint tol);
    n_vec++;
    assert (((obs - exp) <= tol) && ((exp - obs) <= tol)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Present inputs with start for exactly one accepting edge
  task automatic start_op(input longint xv, input longint yv);
    @(negedge clk);
    x_in  = 18'(xv);
    y_in  = 18'(yv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done, bounded; also count busy cycles
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  function automatic longint mag_v();
    return longint'(magnitude);
  endfunction

  function automatic longint ang_v();
    return longint'($signed(angle));
  endfunction

  task automatic run_checked(input string tag, input longint xv, input longint yv);
    int lat, bc;
    longint em, ea;
    start_op(xv, yv);
    wait_done(lat, bc);
    model(xv, yv, em, ea);
    chk({tag, "_lat"}, lat, 18);
    chk({tag, "_mag"}, mag_v(), em);
    chk({tag, "_ang"}, ang_v(), ea);
  endtask

  initial begin
    int lat, bc, seen;
    longint em, ea, xa, ya, xb, yb, old_mag;

    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mag", mag_v(), 0);
    chk("rst_ang", ang_v(), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // (1.0, 0): latency, busy width, ideal result
    start_op(65536, 0);
    chk("acc_busy", longint'(busy), 1);
    chk("acc_done", longint'(done), 0);
    wait_done(lat, bc);
    chk("d1_lat", lat, 18);
    chk("d1_busy_cyc", bc, 18);
    chk("d1_busy_end", longint'(busy), 0);
    chk_tol("d1_mag", mag_v(), 65536, 8);
    chk_tol("d1_ang", ang_v(), 0, 8);
    model(65536, 0, em, ea);
    chk("d1_mag_model", mag_v(), em);

    // (1.0, 1.0): sqrt(2), pi/4
    start_op(65536, 65536);
    wait_done(lat, bc);
    chk_tol("d2_mag", mag_v(), 92682, 8);
    chk_tol("d2_ang", ang_v(), 51472, 8);

    // (-1.0, 0): resolves to +pi
    start_op(-65536, 0);
    wait_done(lat, bc);
    chk_tol("d3_mag", mag_v(), 65536, 8);
    chk_tol("d3_ang", ang_v(), 205887, 8);

    // (0, -1.5): -pi/2
    start_op(0, -98304);
    wait_done(lat, bc);
    chk_tol("d4_mag", mag_v(), 98304, 8);
    chk_tol("d4_ang", ang_v(), -102944, 8);

    // (0, 0): exact zeros
    start_op(0, 0);
    wait_done(lat, bc);
    chk("d5_lat", lat, 18);
    chk("d5_mag", mag_v(), 0);
    chk("d5_ang", ang_v(), 0);

    // Start re-pulsed while busy with other inputs: ignored
    xa = 40000; ya = -70000;
    start_op(xa, ya);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 3 || lat == 10) begin
        x_in  = 18'(-100000);
        y_in  = 18'(12345);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    model(xa, ya, em, ea);
    chk("ign_lat", lat, 18);
    chk("ign_mag", mag_v(), em);
    chk("ign_ang", ang_v(), ea);
    old_mag = em;

    // Restart from DONE: done drops on acceptance, old result held
    xb = -50000; yb = -20000;
    start_op(xb, yb);
    chk("rs_done_drop", longint'(done), 0);
    chk("rs_mag_hold", mag_v(), old_mag);
    wait_done(lat, bc);
    model(xb, yb, em, ea);
    chk("rs_lat", lat, 18);
    chk("rs_mag", mag_v(), em);
    chk("rs_ang", ang_v(), ea);

    // Reset part-way through an operation
    start_op(30000, 30000);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_mag", mag_v(), 0);
    chk("mr_ang", ang_v(), 0);
    chk("mr_busy", longint'(busy), 0);
    chk("mr_done", longint'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("mr_no_done", seen, 0);
    run_checked("mr_after", 77777, -12000);

    // Randomized vectors across the full input range
    for (int k = 0; k < 24; k++) begin
      longint xr, yr;
      xr = longint'($signed(18'($urandom)));
      yr = longint'($signed(18'($urandom)));
      run_checked("rnd", xr, yr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_cordic_vectoring
`default_nettype wire
